// File: rtl/branch_cmp_seq.sv
// Multi-cycle RISC-V branch comparator. It compares one SLICE-bit slice per cycle, starting with the most significant slice.
// Define BRANCH_CMP_EARLY_EXIT_EN to finish on the first differing slice. Result values are the same with or without it.
module branch_cmp_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             equal,
  output logic             greater,
  output logic             less,
  output logic             taken,
  output logic             illegal,
  output logic             busy
);
  localparam int NSLICES = WIDTH / SLICE;
  localparam int IW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic [IW-1:0]    idx;
  logic             decided, lt_q, gt_q;

  logic [NSLICES-1:0][SLICE-1:0] a_v, b_v;
  logic [SLICE-1:0] sa, sb;
  logic [WIDTH-1:0] msk;
  logic             hit, last, done;

  assign a_v = a_q;
  assign b_v = b_q;
  assign sa  = a_v[idx];
  assign sb  = b_v[idx];
  assign hit = (sa != sb) && !decided;

`ifdef BRANCH_CMP_EARLY_EXIT_EN
  assign last = (idx == '0) || hit;
`else
  assign last = (idx == '0);
`endif

  // Flipping both sign bits turns the signed order into the unsigned order.
  always_comb begin
    msk = '0;
    msk[WIDTH-1] = (op == 3'b100) || (op == 3'b101);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      idx     <= '0;
      decided <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q     <= a ^ msk;
          b_q     <= b ^ msk;
          op_q    <= op;
          idx     <= IW'(NSLICES - 1);
          decided <= 1'b0;
          lt_q    <= 1'b0;
          gt_q    <= 1'b0;
          state   <= BUSY;
        end
        BUSY: begin
          // The first differing slice decides the order. Later slices cannot change it.
          if (hit) begin
            decided <= 1'b1;
            lt_q    <= sa < sb;
            gt_q    <= sa > sb;
          end
          if (last) state <= DONE;
          else      idx   <= idx - 1'b1;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign done      = (state == DONE);
  assign out_valid = done;
  assign busy      = (state != IDLE);
  assign in_ready  = (state == IDLE) && !rst;
  assign equal     = done && !decided;
  assign less      = done && lt_q;
  assign greater   = done && gt_q;
  assign illegal   = done && (op_q[2:1] == 2'b01);

  always_comb begin
    taken = 1'b0;
    if (done) begin
      case (op_q)
        3'b000:         taken = !decided;
        3'b001:         taken = decided;
        3'b100, 3'b110: taken = lt_q;
        3'b101, 3'b111: taken = !lt_q;
        default:        taken = 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_cmp_seq.sv
// Directed bench for branch_cmp_seq. A value-level model checks every result cycle.
// Hand literals pin the model for the default 32/8 configuration.
module tb_branch_cmp_seq;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic        equal, greater, less, taken, illegal, busy;
  logic [31:0] a, b;
  logic [2:0]  op;

  branch_cmp_seq #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .equal(equal), .greater(greater), .less(less), .taken(taken),
    .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef BRANCH_CMP_EARLY_EXIT_EN
  localparam int L1 = 1;
  localparam int L3 = 3;
`else
  localparam int L1 = 4;
  localparam int L3 = 4;
`endif

  int   n_assert = 0, n_fail = 0;
  bit   pending = 1'b0;
  logic m_eq, m_lt, m_gt, m_tk, m_il;
  int   m_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model the result from operand values, not from slices.
  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] o,
                                output logic eq, output logic lt, output logic gt,
                                output logic tk, output logic il, output int lat);
    bit sg;
    sg = (o == 3'b100) || (o == 3'b101);
    eq = (x == y);
    lt = sg ? ($signed(x) < $signed(y)) : (x < y);
    gt = sg ? ($signed(x) > $signed(y)) : (x > y);
    il = (o == 3'b010) || (o == 3'b011);
    case (o)
      3'b000:  tk = eq;
      3'b001:  tk = !eq;
      3'b100, 3'b110: tk = lt;
      3'b101, 3'b111: tk = !lt;
      default: tk = 1'b0;
    endcase
    lat = 4;
`ifdef BRANCH_CMP_EARLY_EXIT_EN
    for (int i = 3; i >= 0; i--)
      if (x[8*i +: 8] != y[8*i +: 8]) begin
        lat = 4 - i;
        break;
      end
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (pending && out_valid) begin
        chk("equal", equal, m_eq);
        chk("less", less, m_lt);
        chk("greater", greater, m_gt);
        chk("taken", taken, m_tk);
        chk("illegal", illegal, m_il);
        chk("busy", busy, 1);
        chk("in_ready_in_done", in_ready, 0);
      end else if (!pending) begin
        chk("no_spurious_valid", out_valid, 0);
      end
    end
  end

  task automatic accept(input logic [31:0] ta, input logic [31:0] tb_, input logic [2:0] top, output bit ok);
    int w;
    model(ta, tb_, top, m_eq, m_lt, m_gt, m_tk, m_il, m_lat);
    @(negedge clk);
    a = ta; b = tb_; op = top; in_valid = 1'b1; out_ready = 1'b0;
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    ok = in_ready;
    if (!ok) begin
      chk("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    pending = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Inputs change after acceptance. The result must not depend on them.
    a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic [2:0] top,
                        input int hold, input logic lit_tk, input logic lit_il, input int lit_lat);
    int lat;
    bit ok;
    accept(ta, tb_, top, ok);
    if (!ok) return;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("out_valid_timeout", out_valid, 1);
    chk("latency", lat, m_lat);
    chk("latency_lit", lat, lit_lat);
    chk("taken_lit", taken, lit_tk);
    chk("illegal_lit", illegal, lit_il);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    pending = 1'b0;
    out_ready = 1'b0;
    chk("valid_clear", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_equal"}, equal, 0);
    chk({tag, "_greater"}, greater, 0);
    chk({tag, "_less"}, less, 0);
    chk({tag, "_taken"}, taken, 0);
    chk({tag, "_illegal"}, illegal, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1 reset_chk("rst");
    @(negedge clk) rst = 1'b0;

    run_op(32'h0000_0005, 32'h0000_0005, 3'b000, 0, 1'b1, 1'b0, 4);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 0, 1'b1, 1'b0, L1);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 0, 1'b0, 1'b0, L1);
    run_op(32'h8000_0000, 32'h0000_0000, 3'b111, 0, 1'b1, 1'b0, L1);
    run_op(32'h1234_5678, 32'h1234_5679, 3'b110, 0, 1'b1, 1'b0, 4);
    run_op(32'h0000_0007, 32'h0000_0009, 3'b001, 5, 1'b1, 1'b0, 4);
    run_op(32'h0000_0003, 32'h0000_0003, 3'b010, 0, 1'b0, 1'b1, 4);
    run_op(32'h0000_0100, 32'h0000_0200, 3'b011, 0, 1'b0, 1'b1, L3);
    run_op(32'h8000_0000, 32'h8000_0000, 3'b101, 0, 1'b1, 1'b0, 4);

    // Reset in the middle of BUSY aborts the operation.
    accept(32'h0000_0001, 32'h0000_0002, 3'b100, ok);
    @(posedge clk);
    @(negedge clk) begin rst = 1'b1; pending = 1'b0; end
    @(posedge clk); #1 reset_chk("mid_rst");
    @(negedge clk) rst = 1'b0;
    #1 chk("in_ready_post_rst", in_ready, 1);
    repeat (6) @(negedge clk);

    run_op(32'hFFFF_FFFE, 32'h0000_0003, 3'b101, 0, 1'b0, 1'b0, L1);
    run_op(32'h0000_0000, 32'hFFFF_FFFF, 3'b111, 0, 1'b0, 1'b0, L1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_cmp_seq.md
Name: branch_cmp_seq

Overview:
- Parametrised, multi-cycle successor to the 32-bit combinational comparator; evaluates RISC-V branch conditions.
- Compares WIDTH-bit operands one SLICE-bit slice per cycle, MSB slice first, so wide compares do not sit on the execute critical path.
- Supports signed and unsigned modes selected by the branch funct3 code.
- Sits between register-read and the branch/PC unit, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 32, operand width in bits.
SLICE, 8, bits compared per cycle; must divide WIDTH exactly. NSLICES = WIDTH/SLICE.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
a  in  WIDTH  first operand (rs1)
b  in  WIDTH  second operand (rs2)
op  in  3  funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
equal  out  1  a == b
greater  out  1  a > b (signedness per op)
less  out  1  a < b (signedness per op)
taken  out  1  branch condition true
illegal  out  1  op was 010 or 011
busy  out  1  state != IDLE

Behaviour:
- Reset state while rst=1 at a clock edge:
  - state=IDLE.
  - out_valid, equal, greater, less, taken, illegal, busy all 0.
  - in_ready=0 while rst is high; 1 in IDLE otherwise.
- State machine: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b and op; slice index idx=NSLICES-1; decided=0; go to BUSY.
- Signed mode applies only for op 100 and 101. In signed mode, bit WIDTH-1 of both latched operands is inverted at capture, so the unsigned slice compare yields the signed order.
- BUSY: one slice per cycle, comparing latched a[idx] and b[idx].
  - If the slices differ and decided=0: set decided=1, less=(a_slice<b_slice), greater=(a_slice>b_slice).
  - Results are sticky: later slices never overwrite them.
  - Go to DONE after the slice with idx=0 is evaluated (see Optional Feature for early exit); otherwise idx decrements.
- DONE:
  - out_valid=1.
  - equal = !decided.
  - taken: BEQ=equal, BNE=!equal, BLT/BLTU=less, BGE/BGEU=!less.
  - For op 010 or 011: illegal=1 and taken=0; equal/less/greater are still computed unsigned.
  - All outputs stay stable while out_ready=0.
  - On out_valid&&out_ready: go to IDLE and clear out_valid. in_ready rises the following cycle; there is no same-cycle accept.
- Latency: with the acceptance edge at E0, out_valid rises at edge E0+NSLICES (4 for the defaults). Throughput is one op per NSLICES+2 cycles when out_ready=1.
- In IDLE, in_valid is ignored until in_ready=1. Inputs are sampled only at acceptance, so changes during BUSY/DONE have no effect.
- Reset mid-BUSY or mid-DONE aborts the operation: no out_valid pulse, and the result registers clear.
- WIDTH==SLICE (NSLICES=1) is legal: out_valid rises at E0+1.

Optional Feature:
- Macro: BRANCH_CMP_EARLY_EXIT_EN.
- Defined: BUSY goes to DONE in the same cycle that the first differing slice is found. out_valid then rises at E0+k, where k = 1 + number of equal leading slices. Equal operands still take NSLICES cycles.
- Undefined: fixed latency of NSLICES cycles for every operation.
- Result values are identical in both builds; only latency differs.

Test Plan:
1. WIDTH=32, SLICE=8; a=0x00000005, b=0x00000005, op=BEQ -> equal=1, taken=1, less=greater=0; out_valid rises 4 cycles after accept (both builds).
2. a=0xFFFFFFFF, b=0x00000001 -> op=BLT: less=1, taken=1. op=BLTU: greater=1, less=0, taken=0.
3. a=0x80000000, b=0x00000000, op=BGEU -> greater=1, taken=1. out_valid at E0+1 with BRANCH_CMP_EARLY_EXIT_EN, at E0+4 without. Also a=0x12345678, b=0x12345679 -> less=1, out_valid at E0+4 in both builds.
4. Hold out_ready=0 for 5 cycles in DONE -> out_valid=1 and all results stable, in_ready=0 throughout. Then raise out_ready -> out_valid clears and in_ready=1 on the next cycle.
5. op=3'b010 with a=3, b=3 -> illegal=1, taken=0, equal=1.
6. Assert rst for 1 cycle during BUSY -> out_valid never pulses, all outputs 0, in_ready=1 on the first cycle after reset; a new request then completes normally.
